sd_read_tick_gen: RTL and testbench

//  Byte-stream datapath feeding the FSM2 read sequencer: watches bytes from the SD SPI receiver.

---
 rtl/sd_rd_pkg.sv | 32 +++
 rtl/sd_read_tick_gen_if.sv | 30 +++
 rtl/sd_read_tick_gen_sync_rise.sv | 24 ++
 rtl/sd_read_tick_gen.sv | 172 +++++++++++++++++
 tb/tb_sd_read_tick_gen.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sd_rd_pkg.sv
// Shared constants, state codes and counter-width helpers for the SD read tick generator.
package sd_rd_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TOK  = 3'd1,
        ST_BLK_FIRST = 3'd2,
        ST_GAP       = 3'd3,
        ST_BLK_NEXT  = 3'd4
    } rd_state_e;

    localparam logic [7:0] TOKEN_START = 8'hFE;

    typedef struct packed {
        logic rd;
        logic wt;
        logic crc;
        logic nxt;
        logic lst;
    } tick_t;

    function automatic int byte_cnt_w(input int block_bytes, input int crc_bytes);
        return $clog2(block_bytes + crc_bytes);
    endfunction

    function automatic int blk_cnt_w(input int num_blocks);
        return (num_blocks < 2) ? 1 : $clog2(num_blocks);
    endfunction

endpackage

// File: rtl/sd_read_tick_gen_if.sv
// Byte stream in, FSM2 state in, ticks and payload out.
interface sd_read_tick_gen_if;
    import sd_rd_pkg::*;

    logic [STATE_W-1:0] state_reg;
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               tick_READ;
    logic               tick_WAIT;
    logic               tick_CRC;
    logic               tick_NEXT;
    logic               tick_LAST;
    logic [7:0]         data_out;
    logic               data_valid;
    logic [15:0]        crc_out;
    logic               err_timeout;

    modport slave (
        input  state_reg, byte_valid, byte_data,
        output tick_READ, tick_WAIT, tick_CRC, tick_NEXT, tick_LAST,
        output data_out, data_valid, crc_out, err_timeout
    );

    modport master (
        output state_reg, byte_valid, byte_data,
        input  tick_READ, tick_WAIT, tick_CRC, tick_NEXT, tick_LAST,
        input  data_out, data_valid, crc_out, err_timeout
    );

endinterface

// File: rtl/sd_read_tick_gen_sync_rise.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge pulse.
module sync_rise (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/sd_read_tick_gen.sv
// Byte-stream datapath for the FSM2 read sequencer: tick decode, payload/CRC split,
// byte/block/wait counters, start-request edge detect and token timeout.
module sd_read_tick_gen
    import sd_rd_pkg::*;
#(
    parameter int BLOCK_BYTES = 512,
    parameter int CRC_BYTES   = 2,
    parameter int NUM_BLOCKS  = 4,
    parameter int WAIT_LIMIT  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_req,
    sd_read_tick_gen_if.slave bus
);

    localparam int BCW = byte_cnt_w(BLOCK_BYTES, CRC_BYTES);
    localparam int BKW = blk_cnt_w(NUM_BLOCKS);
    localparam int WCW = $clog2(WAIT_LIMIT);

    localparam logic [BCW-1:0] PAY_END  = BCW'(BLOCK_BYTES);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(BLOCK_BYTES + CRC_BYTES - 1);
    localparam logic [BKW-1:0] BLK_LAST = BKW'(NUM_BLOCKS - 1);
    localparam logic [WCW-1:0] WAIT_END = WCW'(WAIT_LIMIT - 1);

    if (NUM_BLOCKS < 2) begin : g_chk_blocks
        $error("sd_read_tick_gen: NUM_BLOCKS must be >= 2");
    end

    logic      rise;
    rd_state_e st;

    sync_rise u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (start_req),
        .rise_o  (rise)
    );

    assign st = rd_state_e'(bus.state_reg);

    logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [BKW-1:0]     blk_cnt_q,  blk_cnt_d;
    logic [WCW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [15:0]        crc_sh_q,   crc_sh_d;
    logic [15:0]        crc_out_q,  crc_out_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               data_vld_q, data_vld_d;
    logic               err_q,      err_d;
    tick_t              tick_q,     tick_d;
    logic               hold_q,     hold_d;
    logic [STATE_W-1:0] hold_st_q,  hold_st_d;
    tick_t              tk;
    logic               masked;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        wait_cnt_d = wait_cnt_q;
        crc_sh_d   = crc_sh_q;
        crc_out_d  = crc_out_q;
        data_out_d = data_out_q;
        data_vld_d = 1'b0;
        err_d      = err_q;
        hold_st_d  = hold_st_q;
        tk         = '0;

        case (st)
            ST_IDLE: begin
                byte_cnt_d = '0;
                blk_cnt_d  = '0;
                wait_cnt_d = '0;
                tk.rd      = rise;
            end
            ST_WAIT_TOK: begin
                if (bus.byte_valid) begin
                    if (bus.byte_data == TOKEN_START) begin
                        tk.wt      = 1'b1;
                        byte_cnt_d = '0;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                        if (wait_cnt_q == WAIT_END) err_d = 1'b1;
                    end
                end
            end
            ST_BLK_FIRST, ST_BLK_NEXT: begin
                if (bus.byte_valid) begin
                    if (byte_cnt_q < PAY_END) begin
                        data_out_d = bus.byte_data;
                        data_vld_d = 1'b1;
                    end else begin
                        crc_sh_d = {crc_sh_q[7:0], bus.byte_data};
                    end
                    if (byte_cnt_q == LAST_IDX) begin
                        crc_out_d  = {crc_sh_q[7:0], bus.byte_data};
                        byte_cnt_d = '0;
                        if (st == ST_BLK_NEXT && blk_cnt_q == BLK_LAST) begin
                            tk.lst = 1'b1;
                        end else begin
                            tk.crc    = 1'b1;
                            blk_cnt_d = blk_cnt_q + 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // Busy bytes (0xFF) are simply skipped until the next start token.
                if (bus.byte_valid && bus.byte_data == TOKEN_START) begin
                    tk.nxt     = 1'b1;
                    byte_cnt_d = '0;
                end
            end
            default: begin
                byte_cnt_d = '0;
                blk_cnt_d  = '0;
                wait_cnt_d = '0;
            end
        endcase

        // Mask ticks until FSM2 has visibly left the state it was in when the last tick fired.
        masked = hold_q && (bus.state_reg == hold_st_q);
        tick_d = masked ? tick_t'('0) : tk;
        hold_d = masked;
        if (tick_d != '0) begin
            hold_d    = 1'b1;
            hold_st_d = bus.state_reg;
        end
        if (tick_d.rd) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
            blk_cnt_q  <= '0;
            wait_cnt_q <= '0;
            crc_sh_q   <= '0;
            crc_out_q  <= '0;
            data_out_q <= '0;
            data_vld_q <= 1'b0;
            err_q      <= 1'b0;
            tick_q     <= '0;
            hold_q     <= 1'b0;
            hold_st_q  <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            crc_sh_q   <= crc_sh_d;
            crc_out_q  <= crc_out_d;
            data_out_q <= data_out_d;
            data_vld_q <= data_vld_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
            hold_q     <= hold_d;
            hold_st_q  <= hold_st_d;
        end
    end

    assign bus.tick_READ   = tick_q.rd;
    assign bus.tick_WAIT   = tick_q.wt;
    assign bus.tick_CRC    = tick_q.crc;
    assign bus.tick_NEXT   = tick_q.nxt;
    assign bus.tick_LAST   = tick_q.lst;
    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_vld_q;
    assign bus.crc_out     = crc_out_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_sd_read_tick_gen.sv
// Directed bench: FSM2 is modelled as a registered state fed back from the ticks.
module tb_sd_read_tick_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_req = 1'b0;

    sd_read_tick_gen_if bus ();

    sd_read_tick_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start_req (start_req),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // FSM2 model with override for hold-off and timeout scenarios
    logic [2:0] st_q;
    logic       force_en = 1'b0;
    logic [2:0] force_val = 3'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) st_q <= 3'd0;
        else if (force_en) st_q <= force_val;
        else begin
            case (st_q)
                3'd0: if (bus.tick_READ) st_q <= 3'd1;
                3'd1: if (bus.tick_WAIT) st_q <= 3'd2;
                3'd2, 3'd4: begin
                    if (bus.tick_CRC) st_q <= 3'd3;
                    else if (bus.tick_LAST) st_q <= 3'd0;
                end
                3'd3: if (bus.tick_NEXT) st_q <= 3'd4;
                default: st_q <= 3'd0;
            endcase
        end
    end
    assign bus.state_reg = st_q;

    // Output monitor: tick counts and in-order payload check
    int cnt_read = 0, cnt_wait = 0, cnt_crc = 0, cnt_next = 0, cnt_last = 0, cnt_both = 0;
    int dv_idx = 0, dv_bad = 0;

    always @(negedge clk) begin
        if (bus.tick_READ) cnt_read <= cnt_read + 1;
        if (bus.tick_WAIT) cnt_wait <= cnt_wait + 1;
        if (bus.tick_CRC)  cnt_crc  <= cnt_crc + 1;
        if (bus.tick_NEXT) cnt_next <= cnt_next + 1;
        if (bus.tick_LAST) cnt_last <= cnt_last + 1;
        if (bus.tick_CRC && bus.tick_LAST) cnt_both <= cnt_both + 1;
        if (rst) dv_idx <= 0;
        else if (bus.data_valid) begin
            if (bus.data_out !== dv_idx[7:0]) dv_bad <= dv_bad + 1;
            dv_idx <= dv_idx + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_block();
        for (int i = 0; i < 512; i++) send_byte(8'(i));
        send_byte(8'hA5);
        send_byte(8'h5A);
    endtask

    task automatic start_edge();
        start_req = 1'b0;
        repeat (3) @(negedge clk);
        start_req = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic full_read();
        send_byte(8'hFE);
        send_block();
        for (int k = 1; k < 4; k++) begin
            send_byte(8'hFF);
            send_byte(8'hFE);
            send_block();
        end
        repeat (3) @(negedge clk);
    endtask

    logic [4:0] ticks;
    assign ticks = {bus.tick_READ, bus.tick_WAIT, bus.tick_CRC, bus.tick_NEXT, bus.tick_LAST};

    int s_read, s_crc, s_last, s_next, s_tot, s_dv;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1. reset state and start-request edge
        chk("rst_ticks", 32'(ticks), 32'h0);
        chk("rst_dvalid", 32'(bus.data_valid), 32'h0);
        chk("rst_crc", 32'(bus.crc_out), 32'h0);
        chk("rst_err", 32'(bus.err_timeout), 32'h0);
        start_req = 1'b1;
        @(negedge clk); chk("read_c1", 32'(bus.tick_READ), 32'h0);
        @(negedge clk); chk("read_c2", 32'(bus.tick_READ), 32'h0);
        @(negedge clk); chk("read_c3", 32'(bus.tick_READ), 32'h1);
        @(negedge clk); chk("read_c4", 32'(bus.tick_READ), 32'h0);
        repeat (10) @(negedge clk);
        chk("read_once", 32'(cnt_read), 32'd1);
        chk("st_wait_tok", 32'(st_q), 32'd1);
        start_req = 1'b0;

        // 2. start token detection
        send_byte(8'hFF);
        send_byte(8'hFF);
        chk("wait_on_ff", 32'(cnt_wait), 32'd0);
        send_byte(8'hFE);
        chk("wait_on_fe", 32'(cnt_wait), 32'd1);
        chk("err_after_tok", 32'(bus.err_timeout), 32'h0);
        chk("st_blk_first", 32'(st_q), 32'd2);

        // 3. full four-block read
        send_block();
        for (int k = 1; k < 4; k++) begin
            send_byte(8'hFF);
            send_byte(8'hFE);
            send_block();
        end
        repeat (3) @(negedge clk);
        chk("rd_dv_count", 32'(dv_idx), 32'd2048);
        chk("rd_dv_order", 32'(dv_bad), 32'd0);
        chk("rd_crc_ticks", 32'(cnt_crc), 32'd3);
        chk("rd_next_ticks", 32'(cnt_next), 32'd3);
        chk("rd_last_ticks", 32'(cnt_last), 32'd1);
        chk("rd_no_both", 32'(cnt_both), 32'd0);
        chk("rd_crc_out", 32'(bus.crc_out), 32'hA55A);
        chk("rd_end_idle", 32'(st_q), 32'd0);

        // 4. start-token timeout and clear by tick_READ
        start_edge();
        chk("to_read", 32'(cnt_read), 32'd2);
        chk("to_state", 32'(st_q), 32'd1);
        for (int i = 0; i < 4095; i++) send_byte(8'hFF);
        chk("to_4095", 32'(bus.err_timeout), 32'h0);
        send_byte(8'hFF);
        chk("to_4096", 32'(bus.err_timeout), 32'h1);
        chk("to_no_wait", 32'(cnt_wait), 32'd1);
        force_val = 3'd0;
        force_en  = 1'b1;
        repeat (2) @(negedge clk);
        force_en  = 1'b0;
        chk("to_sticky", 32'(bus.err_timeout), 32'h1);
        start_edge();
        chk("to_read2", 32'(cnt_read), 32'd3);
        chk("to_cleared", 32'(bus.err_timeout), 32'h0);

        // 5. reset in the middle of block 2
        start_req = 1'b0;
        send_byte(8'hFE);
        send_block();
        send_byte(8'hFE);
        send_block();
        send_byte(8'hFE);
        for (int i = 0; i < 300; i++) send_byte(8'(i));
        chk("mid_dv_count", 32'(dv_idx), 32'd3372);
        s_tot = cnt_read + cnt_wait + cnt_crc + cnt_next + cnt_last;
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'd44;
        rst = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        chk("mrst_ticks", 32'(ticks), 32'h0);
        chk("mrst_dvalid", 32'(bus.data_valid), 32'h0);
        chk("mrst_dout", 32'(bus.data_out), 32'h0);
        chk("mrst_crc", 32'(bus.crc_out), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mrst_no_dv", 32'(dv_idx), 32'd0);
        chk("mrst_no_tick", 32'(cnt_read + cnt_wait + cnt_crc + cnt_next + cnt_last), 32'(s_tot));
        chk("mrst_idle", 32'(st_q), 32'd0);
        s_read = cnt_read; s_crc = cnt_crc; s_last = cnt_last;
        start_edge();
        chk("fresh_read", 32'(cnt_read - s_read), 32'd1);
        full_read();
        chk("fresh_dv", 32'(dv_idx), 32'd2048);
        chk("fresh_order", 32'(dv_bad), 32'd0);
        chk("fresh_crc", 32'(cnt_crc - s_crc), 32'd3);
        chk("fresh_last", 32'(cnt_last - s_last), 32'd1);
        chk("fresh_crc_out", 32'(bus.crc_out), 32'hA55A);
        chk("fresh_idle", 32'(st_q), 32'd0);

        // 6. hold-off: FSM2 stuck in block state after tick_CRC
        start_edge();
        start_req = 1'b0;
        send_byte(8'hFE);
        chk("ho_state", 32'(st_q), 32'd2);
        force_val = 3'd2;
        force_en  = 1'b1;
        s_crc = cnt_crc; s_last = cnt_last; s_next = cnt_next; s_dv = dv_idx;
        send_block();
        chk("ho_first_crc", 32'(cnt_crc - s_crc), 32'd1);
        send_block();
        chk("ho_masked_crc", 32'(cnt_crc - s_crc), 32'd1);
        chk("ho_masked_last", 32'(cnt_last - s_last), 32'd0);
        chk("ho_bytes_count", 32'(dv_idx - s_dv), 32'd1024);
        force_val = 3'd3;
        repeat (2) @(negedge clk);
        force_en  = 1'b0;
        send_byte(8'hFE);
        chk("ho_rearm_next", 32'(cnt_next - s_next), 32'd1);
        chk("ho_rearm_state", 32'(st_q), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
